// File: rtl/cpc_ram_pkg.sv
// Shared definitions for the CPC RAM banking controller: config modes, the
// 6128-style page map and the I/O port match values.
`ifndef CPC_RAM_PKG_SV
`define CPC_RAM_PKG_SV

// True when the fitted SRAM covers every expansion page the bank bits can name.
`define CPC_RAM_CAP_OK(nsram, hi_w, ext_bits) (((nsram) * (2 ** (hi_w))) >= (32 * (2 ** (ext_bits))))

package cpc_ram_pkg;

  typedef enum logic [2:0] {
    MODE_ALL_INT   = 3'd0,
    MODE_TOP_EXT   = 3'd1,
    MODE_ALL_EXT   = 3'd2,
    MODE_TOP_REMAP = 3'd3,
    MODE_P1_E0     = 3'd4,
    MODE_P1_E1     = 3'd5,
    MODE_P1_E2     = 3'd6,
    MODE_P1_E3     = 3'd7
  } mode_e;

  typedef struct packed {
    logic       is_ext;
    logic [1:0] x;
  } page_map_t;

  localparam logic [1:0] PORT_D_MATCH   = 2'b11;
  localparam logic       PORT_A15_MATCH = 1'b0;

  // Internal pages report x=0 so the linear page is well defined in every mode.
  function automatic page_map_t map_page(input logic [2:0] mode, input logic [1:0] page);
    page_map_t m;
    m.is_ext = 1'b0;
    m.x      = 2'd0;
    case (mode_e'(mode))
      MODE_ALL_INT: m.is_ext = 1'b0;
      MODE_TOP_EXT, MODE_TOP_REMAP: begin
        if (page == 2'd3) begin
          m.is_ext = 1'b1;
          m.x      = 2'd3;
        end
      end
      MODE_ALL_EXT: begin
        m.is_ext = 1'b1;
        m.x      = page;
      end
      default: begin
        if (page == 2'd1) begin
          m.is_ext = 1'b1;
          m.x      = mode[1:0];
        end
      end
    endcase
    return m;
  endfunction

endpackage

`endif

// File: rtl/cpc_io_wr_filter.sv
// Debounces the RAM config port write: a hit must persist for WR_FILTER clocks,
// and then produces exactly one accept pulse until the hit drops again.
module cpc_io_wr_filter #(
  parameter int WR_FILTER = 2
) (
  input  logic clk,
  input  logic reset_b,
  input  logic hit,
  output logic accept
);

  localparam logic [2:0] SAT = 3'(WR_FILTER);

  logic [2:0] count_reg;
  logic [2:0] count_next;

  generate
    if (WR_FILTER < 1 || WR_FILTER > 4) begin : g_bad_filter
      $error("cpc_io_wr_filter: WR_FILTER must be 1..4");
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (!hit) begin
      count_next = 3'd0;
    end else if (count_reg != SAT) begin
      count_next = count_reg + 3'd1;
    end
  end

  // Pulse on the clock whose edge brings the count up to SAT; saturation blocks repeats.
  assign accept = reset_b && hit && (count_reg == SAT - 3'd1);

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      count_reg <= 3'd0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM expansion banking controller: snoops the config port, holds the
// banking register and steers CPU 16K pages onto one of several SRAM chips.
module cpc_ram_bank_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int EXT_BANK_BITS = 0,
  parameter int SRAM_HI_W     = 5,
  parameter int NUM_SRAM      = 1,
  parameter int WR_FILTER     = 2
) (
  input  logic                       CLK,
  input  logic                       RESET_B,
  input  logic                       MREQ_B,
  input  logic                       IOREQ_B,
  input  logic                       RD_B,
  input  logic                       WR_B,
  input  logic                       M1_B,
  input  logic                       RFSH_B,
  input  logic [15:0]                A,
  input  logic [7:0]                 D,
  input  logic                       ROMEN_B,
  output logic [SRAM_HI_W-1:0]       HIADR,
  output logic [NUM_SRAM-1:0]        RAMCS_B,
  output logic                       RAMOE_B,
  output logic                       RAMWE_B,
  output logic                       RAMDIS,
  output logic [5+EXT_BANK_BITS:0]   CFG
);

  localparam int CW = 6 + EXT_BANK_BITS;
  localparam int PW = 5 + EXT_BANK_BITS;
  localparam int WW = PW + SRAM_HI_W;

  generate
    if (EXT_BANK_BITS < 0 || EXT_BANK_BITS > 3) begin : g_bad_ext
      $error("cpc_ram_bank_ctrl: EXT_BANK_BITS must be 0..3");
    end
    if (!(`CPC_RAM_CAP_OK(NUM_SRAM, SRAM_HI_W, EXT_BANK_BITS))) begin : g_bad_capacity
      $error("cpc_ram_bank_ctrl: fitted SRAM smaller than addressable expansion");
    end
  endgenerate

  logic          hit;
  logic          accept;
  logic [CW-1:0] load_val;
  logic [CW-1:0] cfg_reg;
  logic [CW-1:0] cfg_next;

  assign hit = !IOREQ_B && !WR_B && M1_B
               && (A[15] == PORT_A15_MATCH)
               && (D[7:6] == PORT_D_MATCH);

  cpc_io_wr_filter #(
    .WR_FILTER (WR_FILTER)
  ) u_wr_filter (
    .clk     (CLK),
    .reset_b (RESET_B),
    .hit     (hit),
    .accept  (accept)
  );

  // Extended bank bits arrive inverted on the port address high byte.
  generate
    if (EXT_BANK_BITS > 0) begin : g_ext_load
      assign load_val = {~A[8+EXT_BANK_BITS-1:8], D[5:0]};
    end else begin : g_no_ext_load
      assign load_val = D[5:0];
    end
  endgenerate

  always_comb begin
    cfg_next = cfg_reg;
    if (accept) begin
      cfg_next = load_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      cfg_reg <= '0;
    end else begin
      cfg_reg <= cfg_next;
    end
  end

  assign CFG = cfg_reg;

  page_map_t     pm;
  logic [PW-1:0] lin_page;
  logic [WW-1:0] p_wide;
  logic [WW-1:0] chip;
  logic          acc;

  assign pm = map_page(cfg_reg[2:0], A[15:14]);

  // cfg_reg above the mode field is exactly {ext, bank}, the top of the linear page.
  assign lin_page = {cfg_reg[CW-1:3], pm.x};
  assign p_wide   = {{SRAM_HI_W{1'b0}}, lin_page};
  assign chip     = p_wide >> SRAM_HI_W;
  assign HIADR    = p_wide[SRAM_HI_W-1:0];

  assign acc     = !MREQ_B && RFSH_B && pm.is_ext;
  assign RAMDIS  = acc && !(!RD_B && !ROMEN_B);
  assign RAMOE_B = !(RAMDIS && !RD_B);
  assign RAMWE_B = !(RAMDIS && !WR_B);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRAM; gi++) begin : g_cs
      assign RAMCS_B[gi] = !(RAMDIS && (chip == WW'(gi)));
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = &{1'b0, A[13:0]};

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Bench for cpc_ram_bank_ctrl: a default 512K instance and a 4MB/8-chip
// instance share one Z80 bus and are checked against a page-level model.
module tb_cpc_ram_bank_ctrl;

  localparam int F = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET_B, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B, ROMEN_B;
  logic [15:0] A;
  logic [7:0]  D;

  logic [4:0] hiadr0;
  logic [0:0] cs0;
  logic       oe0, we0, dis0;
  logic [5:0] cfg0;
  logic [4:0] hiadr1;
  logic [7:0] cs1;
  logic       oe1, we1, dis1;
  logic [8:0] cfg1;

  int n_checks = 0;
  int n_fail   = 0;
  int m_mode, m_bank, m_ext, m_run;

  cpc_ram_bank_ctrl #(.EXT_BANK_BITS(0), .SRAM_HI_W(5), .NUM_SRAM(1), .WR_FILTER(F)) dut0 (
    .CLK(CLK), .RESET_B(RESET_B), .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B),
    .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B), .A(A), .D(D), .ROMEN_B(ROMEN_B),
    .HIADR(hiadr0), .RAMCS_B(cs0), .RAMOE_B(oe0), .RAMWE_B(we0), .RAMDIS(dis0), .CFG(cfg0)
  );

  cpc_ram_bank_ctrl #(.EXT_BANK_BITS(3), .SRAM_HI_W(5), .NUM_SRAM(8), .WR_FILTER(F)) dut1 (
    .CLK(CLK), .RESET_B(RESET_B), .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B),
    .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B), .A(A), .D(D), .ROMEN_B(ROMEN_B),
    .HIADR(hiadr1), .RAMCS_B(cs1), .RAMOE_B(oe1), .RAMWE_B(we1), .RAMDIS(dis1), .CFG(cfg1)
  );

  task automatic bus_idle();
    MREQ_B = 1; IOREQ_B = 1; RD_B = 1; WR_B = 1; M1_B = 1; RFSH_B = 1; ROMEN_B = 1;
    A = 16'h0000; D = 8'h00;
  endtask

  // One clock: the model sees the same inputs the DUT samples at the edge.
  task automatic cyc();
    @(posedge CLK);
    if (!RESET_B) begin
      m_mode = 0; m_bank = 0; m_ext = 0; m_run = 0;
    end else if (!IOREQ_B && !WR_B && M1_B && !A[15] && D[7:6] == 2'b11) begin
      m_run++;
      if (m_run == F) begin
        m_mode = int'(D[2:0]);
        m_bank = int'(D[5:3]);
        m_ext  = 7 - int'(A[10:8]);
      end
    end else begin
      m_run = 0;
    end
    @(negedge CLK);
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int n);
    bus_idle();
    A = addr; D = data; IOREQ_B = 0; WR_B = 0;
    repeat (n) cyc();
    bus_idle();
    cyc();
  endtask

  // Expected decode from the page map rules; ext=0 models the 512K instance.
  task automatic model_out(input int ext, output logic dis, output logic [7:0] cs,
                           output logic oe, output logic we, output logic [4:0] hi);
    int  page, x, lin;
    bit  is_e;
    page = int'(A[15:14]);
    is_e = 0;
    x    = 0;
    if (m_mode == 2) begin
      is_e = 1; x = page;
    end else if ((m_mode == 1 || m_mode == 3) && page == 3) begin
      is_e = 1; x = 3;
    end else if (m_mode >= 4 && page == 1) begin
      is_e = 1; x = m_mode - 4;
    end
    lin = ext * 32 + m_bank * 4 + x;
    dis = is_e && !MREQ_B && RFSH_B && (ROMEN_B || RD_B);
    cs  = 8'hFF;
    if (dis) cs[lin / 32] = 1'b0;
    oe  = !(dis && !RD_B);
    we  = !(dis && !WR_B);
    hi  = 5'(lin % 32);
  endtask

  task automatic test_reset();
    logic [31:0] got, want;
    RESET_B = 0; bus_idle();
    cyc(); cyc();
    got = {dis0, cs0, oe0, we0, hiadr0, cfg0}; want = {1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 6'd0};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_dut0 got=%h want=%h", got, want); end
    got = {dis1, cs1, oe1, we1, hiadr1, cfg1}; want = {1'b0, 8'hFF, 1'b1, 1'b1, 5'd0, 9'd0};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_dut1 got=%h want=%h", got, want); end
    RESET_B = 1;
    cyc();
    MREQ_B = 0; RD_B = 0; A = 16'hC000; #1;
    got = {dis0, cs0, cfg0, dis1, cs1}; want = {1'b0, 1'b1, 6'd0, 1'b0, 8'hFF};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_read got=%h want=%h", got, want); end
    $display("txn reset done");
    bus_idle();
  endtask

  task automatic test_port_write();
    logic [31:0] got, want;
    bus_idle();
    A = 16'h7F00; D = 8'hC1; IOREQ_B = 0; WR_B = 0;
    cyc();
    got = cfg0; want = 0;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL wr_cycle1 got=%h want=%h", got, want); end
    cyc();
    got = {cfg0, cfg1}; want = {6'h01, 9'h001};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL wr_accept got=%h want=%h", got, want); end
    D = 8'hC5;
    cyc();
    got = cfg0; want = 6'h01;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL wr_single_load got=%h want=%h", got, want); end
    bus_idle();
    cyc();
    MREQ_B = 0; RD_B = 0; A = 16'hC123; #1;
    got = {dis0, cs0, oe0, we0, hiadr0}; want = {1'b1, 1'b0, 1'b0, 1'b1, 5'd3};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL mode1_read0 got=%h want=%h", got, want); end
    got = {dis1, cs1, hiadr1}; want = {1'b1, 8'hFE, 5'd3};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL mode1_read1 got=%h want=%h", got, want); end
    $display("txn port_write OUT 7F00,C1");
    bus_idle();
  endtask

  task automatic test_mode_map();
    logic [31:0] got, want;
    io_write(16'h7F00, 8'hC4, 3);
    MREQ_B = 0; RD_B = 0; A = 16'h4000; #1;
    got = {dis0, cs0, hiadr0}; want = {1'b1, 1'b0, 5'd0};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL mode4_p1 got=%h want=%h", got, want); end
    io_write(16'h7F00, 8'hCF, 3);
    MREQ_B = 0; RD_B = 0; A = 16'h4000; #1;
    got = {dis0, cs0, hiadr0, cfg0}; want = {1'b1, 1'b0, 5'd7, 6'h0F};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL mode7_p1 got=%h want=%h", got, want); end
    A = 16'h8000; #1;
    got = {dis0, cs0, oe0}; want = {1'b0, 1'b1, 1'b1};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL mode7_p2 got=%h want=%h", got, want); end
    $display("txn mode_map C4/CF");
    bus_idle();
  endtask

  task automatic test_ext_bank();
    logic [31:0] got, want;
    io_write(16'h7800, 8'hFE, 3);
    MREQ_B = 0; RD_B = 0; A = 16'h4000; #1;
    got = {dis1, cs1, hiadr1, cfg1}; want = {1'b1, 8'h7F, 5'd30, 9'h1FE};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ext_bank1 got=%h want=%h", got, want); end
    got = {dis0, cs0, hiadr0, cfg0}; want = {1'b1, 1'b0, 5'd30, 6'h3E};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ext_bank0 got=%h want=%h", got, want); end
    $display("txn ext_bank OUT 7800,FE");
    bus_idle();
  endtask

  task automatic test_glitch();
    logic [31:0] got, want;
    io_write(16'h7F00, 8'hC1, 3);
    A = 16'h7F00; D = 8'hC2; IOREQ_B = 0; WR_B = 0;
    cyc();
    bus_idle(); cyc();
    got = {cfg0, cfg1}; want = {6'h01, 9'h001};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL glitch_1cyc got=%h want=%h", got, want); end
    A = 16'h7F00; D = 8'hC2; IOREQ_B = 0; WR_B = 0; M1_B = 0;
    repeat (3) cyc();
    bus_idle(); cyc();
    got = cfg0; want = 6'h01;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL glitch_m1 got=%h want=%h", got, want); end
    A = 16'hFF00; D = 8'hC2; IOREQ_B = 0; WR_B = 0;
    repeat (3) cyc();
    bus_idle(); cyc();
    got = cfg0; want = 6'h01;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL glitch_a15 got=%h want=%h", got, want); end
    A = 16'h7F00; D = 8'h82; IOREQ_B = 0; WR_B = 0;
    repeat (3) cyc();
    bus_idle(); cyc();
    got = cfg0; want = 6'h01;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL glitch_d76 got=%h want=%h", got, want); end
    $display("txn glitch filters");
  endtask

  task automatic test_rom_overlay();
    logic [31:0] got, want;
    io_write(16'h7F00, 8'hC2, 3);
    MREQ_B = 0; RD_B = 0; ROMEN_B = 0; A = 16'h0000; #1;
    got = {dis0, cs0, oe0, we0}; want = {1'b0, 1'b1, 1'b1, 1'b1};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rom_read got=%h want=%h", got, want); end
    RD_B = 1; WR_B = 0; #1;
    got = {dis0, cs0, oe0, we0, hiadr0, cs1}; want = {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'hFE};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rom_write got=%h want=%h", got, want); end
    ROMEN_B = 1; RD_B = 0; WR_B = 1; A = 16'h8000; #1;
    got = {dis0, cs0, oe0, we0, hiadr0}; want = {1'b1, 1'b0, 1'b0, 1'b1, 5'd2};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ram_read got=%h want=%h", got, want); end
    $display("txn rom_overlay mode2");
    bus_idle();
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] got, want;
    A = 16'h7F00; D = 8'hC5; IOREQ_B = 0; WR_B = 0;
    cyc();
    RESET_B = 0;
    cyc();
    got = {cfg0, cfg1}; want = 0;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_mid got=%h want=%h", got, want); end
    RESET_B = 1;
    cyc();
    got = cfg0; want = 0;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_refilter1 got=%h want=%h", got, want); end
    cyc();
    got = cfg0; want = 6'h05;
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_refilter2 got=%h want=%h", got, want); end
    $display("txn reset_mid_write");
    bus_idle(); cyc();
  endtask

  task automatic test_refresh();
    logic [31:0] got, want;
    MREQ_B = 0; RFSH_B = 0; RD_B = 0; A = 16'h4000; #1;
    got = {dis0, cs0, oe0, cs1, dis1}; want = {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL refresh got=%h want=%h", got, want); end
    RFSH_B = 1; #1;
    got = {dis0, cs0, hiadr0}; want = {1'b1, 1'b0, 5'd1};
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL refresh_off got=%h want=%h", got, want); end
    $display("txn refresh");
    bus_idle();
  endtask

  task automatic test_random();
    logic [31:0] got, want;
    logic        d, o, w;
    logic [7:0]  c;
    logic [4:0]  h;
    for (int t = 0; t < 160; t++) begin
      int kind, len;
      kind = int'($urandom_range(0, 5));
      len  = int'($urandom_range(1, 4));
      bus_idle();
      A = 16'($urandom); D = 8'($urandom); ROMEN_B = 1'($urandom_range(0, 1));
      case (kind)
        1: begin MREQ_B = 0; RD_B = 0; end
        2: begin MREQ_B = 0; WR_B = 0; end
        3: begin MREQ_B = 0; RFSH_B = 0; end
        4: begin
          IOREQ_B = 0; WR_B = 0; A[15] = 1'b0; D[7:6] = 2'b11;
          M1_B = ($urandom_range(0, 7) != 0);
        end
        5: if ($urandom_range(0, 3) == 0) RESET_B = 0;
        default: ;
      endcase
      $display("txn %0d kind=%0d a=%h d=%h romen_b=%b rst_b=%b len=%0d",
               t, kind, A, D, ROMEN_B, RESET_B, len);
      for (int k = 0; k < len; k++) begin
        #1;
        model_out(0, d, c, o, w, h);
        got = {dis0, cs0, oe0, we0, hiadr0, cfg0};
        want = {d, c[0], o, w, h, 6'(m_bank * 8 + m_mode)};
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL rand0 txn=%0d got=%h want=%h", t, got, want); end
        model_out(m_ext, d, c, o, w, h);
        got = {dis1, cs1, oe1, we1, hiadr1, cfg1};
        want = {d, c, o, w, h, 9'(m_ext * 64 + m_bank * 8 + m_mode)};
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL rand1 txn=%0d got=%h want=%h", t, got, want); end
        cyc();
      end
      RESET_B = 1;
    end
    bus_idle();
  endtask

  initial begin
    m_mode = 0; m_bank = 0; m_ext = 0; m_run = 0;
    RESET_B = 0;
    bus_idle();
    @(negedge CLK);
    test_reset();
    test_port_write();
    test_mode_map();
    test_ext_bank();
    test_glitch();
    test_rom_overlay();
    test_reset_mid_write();
    test_refresh();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
